// File: rtl/shift_4bit_if.sv
// Operand/result bundle for the registered barrel shifter.
// The master drives operands; the slave (the shifter) returns both results.
interface shift_4bit_if #(
   parameter int WIDTH = 4,
   parameter int SHW   = $clog2(WIDTH)
);
   logic [WIDTH-1:0] a;
   logic [SHW-1:0]   shift;
   logic [1:0]       mode;
   logic             in_valid;
   logic [WIDTH-1:0] l_shift;
   logic [WIDTH-1:0] r_shift;
   logic             out_valid;

   modport master (
      output a, shift, mode, in_valid,
      input  l_shift, r_shift, out_valid
   );

   modport slave (
      input  a, shift, mode, in_valid,
      output l_shift, r_shift, out_valid
   );
endinterface

// File: rtl/shift_4bit.sv
// Registered barrel shifter: left and right results by the same amount in
// parallel, with logical, arithmetic and rotate modes and one cycle of latency.
module shift_4bit #(
   parameter int WIDTH = 4,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   shift_4bit_if.slave bus
);
   logic             rotate;
   logic             arith;
   logic             fill;
   logic [WIDTH-1:0] l_next;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] l_shift_reg;
   logic [WIDTH-1:0] r_shift_reg;
   logic             out_valid_reg;

   // Mode 11 decodes as neither rotate nor arithmetic, i.e. logical.
   assign rotate = (bus.mode == 2'b10);
   assign arith  = (bus.mode == 2'b01);
   assign fill   = arith & bus.a[WIDTH-1];

   // One stage per shift bit, moving by 1, 2, 4, ... positions.
   always_comb begin
      l_next = bus.a;
      r_next = bus.a;
      for (int i = 0; i < SHW; i++) begin
         if (bus.shift[i]) begin
            if (rotate) begin
               l_next = (l_next << (1 << i)) | (l_next >> (WIDTH - (1 << i)));
               r_next = (r_next >> (1 << i)) | (r_next << (WIDTH - (1 << i)));
            end else begin
               l_next = l_next << (1 << i);
               r_next = (r_next >> (1 << i))
                      | (~({WIDTH{1'b1}} >> (1 << i)) & {WIDTH{fill}});
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_shift_reg   <= '0;
         r_shift_reg   <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= bus.in_valid;
         if (bus.in_valid) begin
            l_shift_reg <= l_next;
            r_shift_reg <= r_next;
         end
      end
   end

   assign bus.l_shift   = l_shift_reg;
   assign bus.r_shift   = r_shift_reg;
   assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_shift_4bit.sv
// Directed plus random checks of shift_4bit against a bit-level reference
// model, with expected results queued at drive time and popped on out_valid.
module tb_shift_4bit;
   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;
   logic exp_valid;
   logic [W-1:0] last_l;
   logic [W-1:0] last_r;
   logic [2*W-1:0] exp_q [$];

   shift_4bit_if #(.WIDTH(W)) bus ();

   shift_4bit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_l(input logic [W-1:0] a, input int sh, input logic [1:0] m);
      logic [W-1:0] res;
      for (int i = 0; i < W; i++) begin
         int src;
         src = i - sh;
         if (src >= 0) res[i] = a[src];
         else          res[i] = (m == 2'b10) ? a[src + W] : 1'b0;
      end
      return res;
   endfunction

   function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input int sh, input logic [1:0] m);
      logic [W-1:0] res;
      for (int i = 0; i < W; i++) begin
         int src;
         src = i + sh;
         if (src < W)          res[i] = a[src];
         else if (m == 2'b10)  res[i] = a[src - W];
         else if (m == 2'b01)  res[i] = a[W-1];
         else                  res[i] = 1'b0;
      end
      return res;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag);
      logic [2*W-1:0] e;
      check({tag, ".out_valid"}, {{(W-1){1'b0}}, bus.out_valid}, {{(W-1){1'b0}}, exp_valid});
      if (exp_valid) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s.scoreboard observed=empty expected=entry", tag);
         end else begin
            e = exp_q.pop_front();
            check({tag, ".l_shift"}, bus.l_shift, e[2*W-1:W]);
            check({tag, ".r_shift"}, bus.r_shift, e[W-1:0]);
            last_l = e[2*W-1:W];
            last_r = e[W-1:0];
         end
      end else begin
         check({tag, ".l_hold"}, bus.l_shift, last_l);
         check({tag, ".r_hold"}, bus.r_shift, last_r);
      end
   endtask

   task automatic cycle(input string tag, input logic [W-1:0] a, input logic [1:0] sh,
                        input logic [1:0] m, input logic v,
                        input logic [W-1:0] el, input logic [W-1:0] er);
      @(negedge clk);
      check_out(tag);
      bus.a        = a;
      bus.shift    = sh;
      bus.mode     = m;
      bus.in_valid = v;
      if (v) exp_q.push_back({el, er});
      exp_valid = v;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".l_shift"}, bus.l_shift, '0);
      check({tag, ".r_shift"}, bus.r_shift, '0);
      check({tag, ".out_valid"}, {{(W-1){1'b0}}, bus.out_valid}, '0);
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      exp_valid    = 1'b0;
      last_l       = '0;
      last_r       = '0;
      rst_n        = 1'b0;
      bus.a        = 4'b1111;
      bus.shift    = 2'b00;
      bus.mode     = 2'b00;
      bus.in_valid = 1'b1;

      // Reset held across clock edges with a valid input present.
      repeat (2) begin
         @(negedge clk);
         check_zero("reset");
      end
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;

      // Logical
      cycle("log0", 4'b0010, 2'b00, 2'b00, 1'b1, 4'b0010, 4'b0010);
      cycle("log1", 4'b1000, 2'b01, 2'b00, 1'b1, 4'b0000, 4'b0100);
      cycle("log2", 4'b1111, 2'b10, 2'b00, 1'b1, 4'b1100, 4'b0011);
      cycle("log3", 4'b1001, 2'b11, 2'b00, 1'b1, 4'b1000, 4'b0001);
      // Arithmetic
      cycle("ari0", 4'b1000, 2'b10, 2'b01, 1'b1, 4'b0000, 4'b1110);
      cycle("ari1", 4'b0110, 2'b01, 2'b01, 1'b1, 4'b1100, 4'b0011);
      // Rotate
      cycle("rot0", 4'b1001, 2'b01, 2'b10, 1'b1, 4'b0011, 4'b1100);
      cycle("rot1", 4'b0010, 2'b11, 2'b10, 1'b1, 4'b0001, 4'b0100);
      // Mode 11 behaves as logical
      cycle("m11",  4'b1011, 2'b01, 2'b11, 1'b1, 4'b0110, 4'b0101);
      // Hold across valid gaps, including X on idle inputs
      cycle("hold0", 4'b0101, 2'b01, 2'b00, 1'b1, 4'b1010, 4'b0010);
      cycle("hold1", 4'b1111, 2'b01, 2'b00, 1'b0, 4'b0000, 4'b0000);
      cycle("hold2", 4'bxxxx, 2'bxx, 2'bxx, 1'b0, 4'b0000, 4'b0000);
      cycle("rot2",  4'b0110, 2'b10, 2'b10, 1'b1, 4'b1001, 4'b1001);

      // Asynchronous reset between edges while out_valid is high.
      @(posedge clk);
      #2;
      check_out("pre_rst");
      bus.a        = 4'b1111;
      bus.shift    = 2'b01;
      bus.mode     = 2'b00;
      bus.in_valid = 1'b1;
      rst_n        = 1'b0;
      #1;
      check_zero("async_rst");
      @(posedge clk);
      #2;
      check_zero("rst_drop");
      @(negedge clk);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      exp_valid    = 1'b0;
      last_l       = '0;
      last_r       = '0;
      exp_q.delete();

      // Random traffic against the reference model.
      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] ra;
         logic [1:0]   rs;
         logic [1:0]   rm;
         logic         rv;
         ra = W'($urandom);
         rs = 2'($urandom);
         rm = 2'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         if (!rv && n[0]) ra = 4'bxxxx;
         cycle("rand", ra, rs, rm, rv, ref_l(ra, int'(rs), rm), ref_r(ra, int'(rs), rm));
      end
      cycle("flush0", 4'b0000, 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000);
      cycle("flush1", 4'b0000, 2'b00, 2'b00, 1'b0, 4'b0000, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/shift_4bit.md
Name: shift_4bit

Overview:
- Registered barrel shifter: shifts a WIDTH-bit operand left and right by the same amount, producing both results in parallel.
- A mode input selects logical, arithmetic or rotate behaviour.
- Sits in the datapath as a single-cycle-latency shift unit with a valid qualifier.
- Default configuration is 4-bit operand, 2-bit shift amount, logical mode.

Parameters:
- WIDTH, 4, operand and result width in bits; must be a power of two, ≥ 2.
- SHW, $clog2(WIDTH) (2 at default), width of the shift-amount input.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a  in  WIDTH  operand.
- shift  in  SHW  shift amount, 0..WIDTH-1.
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical.
- in_valid  in  1  operand/shift/mode sampled when high.
- l_shift  out  WIDTH  registered left-shift/rotate result.
- r_shift  out  WIDTH  registered right-shift/rotate result.
- out_valid  out  1  high for one cycle per accepted input.

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk): l_shift=0, r_shift=0, out_valid=0.
  - Held while rst_n is low; release is synchronised by the first rising clk edge.
- Latency: 1 cycle.
  - On a rising clk with in_valid=1, results computed from a/shift/mode are registered.
  - out_valid=1 in the following cycle.
- in_valid=0 at a clock edge: out_valid=0; l_shift/r_shift hold their previous values.
- No back-pressure: every in_valid cycle is accepted. Back-to-back inputs give back-to-back outputs.
- mode 00 (logical) / 11:
  - l_shift = a << shift, zero fill at LSBs.
  - r_shift = a >> shift, zero fill at MSBs.
- mode 01 (arithmetic):
  - l_shift identical to logical.
  - r_shift fills vacated MSBs with a[WIDTH-1].
- mode 10 (rotate):
  - l_shift = rotate-left of a by shift.
  - r_shift = rotate-right of a by shift.
  - No bits lost.
- shift=0: both outputs equal a in every mode.
- shift=WIDTH-1: logical left leaves only a[0] at the MSB; logical right leaves only a[WIDTH-1] at the LSB.
- Width rule: outputs are exactly WIDTH bits; bits shifted past either end are discarded, except in rotate mode.
- Shift network: combinational log2 stages (1, 2, 4, ...) selected by the shift bits, followed by the output register.
- Reset asserted mid-stream clears outputs and out_valid immediately. A pending input at that edge is dropped.
- X/Z on inputs while in_valid=0 must not affect outputs.

Test Plan:
- Reset: rst_n=0 with in_valid=1, a=1111 → l_shift=0000, r_shift=0000, out_valid=0 while low. After release, the first valid input appears one cycle later.
- Logical sequence at 10 ns spacing, mode=00, in_valid=1 each cycle, each result one cycle after its input:
  - a=0010, shift=00 → l=0010, r=0010.
  - a=1000, shift=01 → l=0000, r=0100.
  - a=1111, shift=10 → l=1100, r=0011.
  - a=1001, shift=11 → l=1000, r=0001.
- Arithmetic: mode=01.
  - a=1000, shift=10 → l=0000, r=1110.
  - a=0110, shift=01 → l=1100, r=0011.
- Rotate: mode=10.
  - a=1001, shift=01 → l=0011, r=1100.
  - a=0010, shift=11 → l=0001, r=0100.
- Hold / valid gaps:
  - a=0101, shift=01 valid → l=1010, r=0010, out_valid=1.
  - Next cycle in_valid=0 with a=1111 → outputs stay 1010/0010, out_valid=0.
- Reset mid-stream: assert rst_n low asynchronously between edges while out_valid=1 → outputs clear to 0 immediately, without waiting for clk.
